// File: rtl/rca_result_collector_pkg.sv
// Shared types for the ripple-carry adder result path: operand width,
// the packed {carry, sum} result word and the collector buffer states.
package rca_pkg;

  localparam int RCA_WIDTH = 50;

  typedef logic [RCA_WIDTH:0] rca_result_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } collector_state_t;

endpackage

// File: rtl/rca_result_collector_if.sv
// Adder-side and consumer-side handshake bundle for the result collector.
// Handshake: a transfer happens on a rising clk edge when valid && ready are
// both high; valid never waits on ready, and ready/valid driven by the
// collector are pure decodes of its registered state.
interface rca_result_collector_if
  import rca_pkg::*;
#(
  parameter int WIDTH     = RCA_WIDTH,
  parameter int CNT_WIDTH = 16
);
  logic                 i_valid;
  logic                 o_ready;
  logic [WIDTH:0]       i_result;
  logic                 o_valid;
  logic                 i_ready;
  logic [WIDTH-1:0]     o_sum;
  logic                 o_carry;
  logic [CNT_WIDTH-1:0] o_xfer_count;
  logic [CNT_WIDTH-1:0] o_carry_count;
  collector_state_t     dbg_state;

  modport master (
    output i_valid, i_result, i_ready,
    input  o_ready, o_valid, o_sum, o_carry, o_xfer_count, o_carry_count, dbg_state
  );

  modport slave (
    input  i_valid, i_result, i_ready,
    output o_ready, o_valid, o_sum, o_carry, o_xfer_count, o_carry_count, dbg_state
  );
endinterface

// File: rtl/rca_result_collector_sat_counter.sv
// Registered up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (i_inc && (count_q != '1)) begin
      count_q <= count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rca_result_collector.sv
// Two-entry skid buffer behind the ripple-carry adder, presenting results in
// order to the consumer and keeping saturating push / carry-out statistics.
module rca_result_collector
  import rca_pkg::*;
#(
  parameter int WIDTH     = RCA_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  rca_result_collector_if.slave  bus
);

  collector_state_t state_q, state_d;
  logic [WIDTH:0]   head_q, skid_q;
  logic             push, pop;
  logic             load_head, head_from_skid, load_skid;

  // Both handshake outputs decode the state register only, so the adder and
  // consumer paths never see a combinational loop through this block.
  assign bus.o_valid   = (state_q != EMPTY);
  assign bus.o_ready   = (state_q != FULL);
  assign bus.dbg_state = state_q;

  assign push = bus.i_valid && bus.o_ready;
  assign pop  = bus.o_valid && bus.i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    head_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d   = ONE;
          load_head = 1'b1;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (pop && !push) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          load_head = 1'b1;
        end
      end
      FULL: begin
        if (pop) begin
          state_d        = ONE;
          load_head      = 1'b1;
          head_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_head) begin
        head_q <= head_from_skid ? skid_q : bus.i_result;
      end
      if (load_skid) begin
        skid_q <= bus.i_result;
      end
    end
  end

  assign bus.o_sum   = head_q[WIDTH-1:0];
  assign bus.o_carry = head_q[WIDTH];

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_xfer_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (push),
    .count (bus.o_xfer_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_carry_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (push && bus.i_result[WIDTH]),
    .count (bus.o_carry_count)
  );

endmodule

// File: tb/tb_rca_result_collector.sv
// Directed bench for rca_result_collector: a full-width-counter instance and a
// 4-bit-counter instance see identical stimulus and are checked every cycle.
module tb_rca_result_collector;
  import rca_pkg::*;

  localparam int W = RCA_WIDTH;

  logic clk;
  logic rst;

  rca_result_collector_if #(.WIDTH(W), .CNT_WIDTH(16)) bus_big ();
  rca_result_collector_if #(.WIDTH(W), .CNT_WIDTH(4))  bus_sml ();

  rca_result_collector #(.WIDTH(W), .CNT_WIDTH(16)) dut_big (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_big.slave)
  );

  rca_result_collector #(.WIDTH(W), .CNT_WIDTH(4)) dut_sml (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_sml.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];
  int unsigned exp_xfer, exp_carry;
  int n_checks = 0;
  int n_errors = 0;
  logic m_push, m_pop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

  // Reference: occupancy-bounded FIFO of at most two results, counts unbounded
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      exp_xfer  = 0;
      exp_carry = 0;
    end else begin
      m_pop  = (exp_q.size() > 0) && bus_big.i_ready;
      m_push = bus_big.i_valid && (exp_q.size() < 2);
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        exp_q.push_back(bus_big.i_result);
        exp_xfer++;
        if (bus_big.i_result[W]) exp_carry++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("big_valid", 64'(bus_big.o_valid), 64'(exp_q.size() > 0));
      check("big_ready", 64'(bus_big.o_ready), 64'(exp_q.size() < 2));
      check("sml_valid", 64'(bus_sml.o_valid), 64'(exp_q.size() > 0));
      check("sml_ready", 64'(bus_sml.o_ready), 64'(exp_q.size() < 2));
      if (exp_q.size() > 0) begin
        check("big_sum",   64'(bus_big.o_sum),   64'(exp_q[0][W-1:0]));
        check("big_carry", 64'(bus_big.o_carry), 64'(exp_q[0][W]));
        check("sml_sum",   64'(bus_sml.o_sum),   64'(exp_q[0][W-1:0]));
      end
      check("big_xfer_cnt",  64'(bus_big.o_xfer_count),  64'(sat(exp_xfer, 65535)));
      check("big_carry_cnt", 64'(bus_big.o_carry_count), 64'(sat(exp_carry, 65535)));
      check("sml_xfer_cnt",  64'(bus_sml.o_xfer_count),  64'(sat(exp_xfer, 15)));
      check("sml_carry_cnt", 64'(bus_sml.o_carry_count), 64'(sat(exp_carry, 15)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic r, input logic [W:0] res);
    bus_big.i_valid  = v;
    bus_big.i_ready  = r;
    bus_big.i_result = res;
    bus_sml.i_valid  = v;
    bus_sml.i_ready  = r;
    bus_sml.i_result = res;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [W:0] mk(input logic c, input logic [W-1:0] s);
    return {c, s};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] all_ones;
    all_ones = '1;
    rst = 1'b1;
    drive(1'b0, 1'b0, '0);
    step();
    step();
    check("rst_valid", 64'(bus_big.o_valid), 64'd0);
    check("rst_ready", 64'(bus_big.o_ready), 64'd1);
    check("rst_sum",   64'(bus_big.o_sum),   64'd0);
    check("rst_carry", 64'(bus_big.o_carry), 64'd0);
    rst = 1'b0;
    step();

    // Single push, carry set
    drive(1'b1, 1'b1, mk(1'b1, 50'd5));
    step();
    drive(1'b0, 1'b1, '0);
    check("single_valid", 64'(bus_big.o_valid), 64'd1);
    check("single_sum",   64'(bus_big.o_sum),   64'd5);
    check("single_carry", 64'(bus_big.o_carry), 64'd1);
    check("single_xfer",  64'(bus_big.o_xfer_count),  64'd1);
    check("single_ccnt",  64'(bus_big.o_carry_count), 64'd1);
    step();
    check("single_drain", 64'(bus_big.o_valid), 64'd0);

    // Backpressure: A, B fill the buffer, C must be refused
    drive(1'b1, 1'b0, mk(1'b0, 50'd1));
    step();
    drive(1'b1, 1'b0, mk(1'b0, 50'd2));
    step();
    check("bp_full_ready", 64'(bus_big.o_ready), 64'd0);
    drive(1'b1, 1'b0, mk(1'b1, 50'd3));
    step();
    drive(1'b0, 1'b0, '0);
    check("bp_hold_sum",  64'(bus_big.o_sum), 64'd1);
    check("bp_xfer",      64'(bus_big.o_xfer_count), 64'd3);
    step();
    check("bp_hold_sum2", 64'(bus_big.o_sum), 64'd1);
    drive(1'b0, 1'b1, '0);
    step();
    check("bp_second", 64'(bus_big.o_sum), 64'd2);
    step();
    check("bp_empty", 64'(bus_big.o_valid), 64'd0);

    // Mixed valid/ready patterns
    for (int i = 0; i < 40; i++) begin
      drive((i % 4) != 3, (i % 3) != 0, mk(logic'(i[0] ^ i[1]), 50'(i * 12345 + 7)));
      step();
    end
    drive(1'b0, 1'b1, '0);
    step();
    step();

    // Stream 100 results at full rate
    sync_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b1, mk(logic'(i[0]), 50'(i + 1000)));
      step();
      if (i > 0) check("stream_ready", 64'(bus_big.o_ready), 64'd1);
    end
    drive(1'b0, 1'b1, '0);
    step();
    check("stream_xfer",  64'(bus_big.o_xfer_count),  64'd100);
    check("stream_ccnt",  64'(bus_big.o_carry_count), 64'd50);
    check("stream_sml_x", 64'(bus_sml.o_xfer_count),  64'd15);

    // Saturation: 20 carry-set pushes
    sync_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, mk(1'b1, 50'(i)));
      step();
    end
    drive(1'b0, 1'b1, '0);
    step();
    check("sat_sml_xfer", 64'(bus_sml.o_xfer_count),  64'd15);
    check("sat_sml_ccnt", 64'(bus_sml.o_carry_count), 64'd15);
    check("sat_big_xfer", 64'(bus_big.o_xfer_count),  64'd20);

    // Carry boundary
    sync_reset();
    drive(1'b1, 1'b0, mk(1'b0, all_ones));
    step();
    drive(1'b0, 1'b1, '0);
    check("cb_sum_ones", 64'(bus_big.o_sum),   64'h3_FFFF_FFFF_FFFF);
    check("cb_carry0",   64'(bus_big.o_carry), 64'd0);
    check("cb_ccnt0",    64'(bus_big.o_carry_count), 64'd0);
    step();
    drive(1'b1, 1'b0, mk(1'b1, 50'd0));
    step();
    drive(1'b0, 1'b0, '0);
    check("cb_sum_zero", 64'(bus_big.o_sum),   64'd0);
    check("cb_carry1",   64'(bus_big.o_carry), 64'd1);
    check("cb_ccnt1",    64'(bus_big.o_carry_count), 64'd1);
    check("cb_xfer",     64'(bus_big.o_xfer_count),  64'd2);

    // Asynchronous reset while FULL
    drive(1'b1, 1'b0, mk(1'b1, 50'd9));
    step();
    drive(1'b0, 1'b0, '0);
    check("ar_full", 64'(bus_big.o_ready), 64'd0);
    #3;
    rst = 1'b1;
    #1;
    check("ar_valid", 64'(bus_big.o_valid), 64'd0);
    check("ar_ready", 64'(bus_big.o_ready), 64'd1);
    check("ar_xfer",  64'(bus_big.o_xfer_count),  64'd0);
    check("ar_ccnt",  64'(bus_big.o_carry_count), 64'd0);
    check("ar_sum",   64'(bus_big.o_sum), 64'd0);
    step();
    rst = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rca_result_collector.md
Name: rca_result_collector

Overview:
- Downstream stage of the 50-bit ripple-carry adder. Captures the adder's combinational {carry, sum} result behind a valid/ready handshake.
- Buffers results in a 2-entry skid buffer so the adder-side handshake meets timing. Each stored result is presented to the consumer in order.
- Keeps saturating statistics: accepted results, and accepted results with carry-out set.

Parameters:
- WIDTH, 50, adder operand width; the result bus is WIDTH+1 bits.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_valid  input  1  adder result on i_result is valid
- o_ready  output  1  collector can accept a result this cycle
- i_result  input  WIDTH+1  adder output {carry, sum[WIDTH-1:0]}
- o_valid  output  1  o_sum/o_carry hold a valid result
- i_ready  input  1  consumer accepts the presented result
- o_sum  output  WIDTH  sum of the head entry
- o_carry  output  1  carry-out of the head entry
- o_xfer_count  output  CNT_WIDTH  number of accepted results, saturating
- o_carry_count  output  CNT_WIDTH  number of accepted results with carry=1, saturating

Behaviour:
- Clock and reset:
  - One clock domain (i_clk).
  - i_rst is asynchronous and active-high. Asserting it immediately forces:
    - state EMPTY
    - o_valid=0, o_ready=1
    - o_sum=0, o_carry=0
    - o_xfer_count=0, o_carry_count=0
  - Reset mid-operation drops all buffered results with no partial output.
- Handshake:
  - push = i_valid && o_ready.
  - pop = o_valid && i_ready.
  - Transfers happen on the rising edge only.
  - i_result is sampled only on push.
- Storage:
  - Head register (drives o_sum/o_carry) plus skid register.
  - o_ready and o_valid are pure decodes of the registered state; neither depends combinationally on i_valid or i_ready.
- States and transitions:
  - EMPTY: o_valid=0, o_ready=1.
    - push → ONE; the head loads i_result.
  - ONE: o_valid=1, o_ready=1.
    - push && !pop → FULL; the skid loads i_result.
    - pop && !push → EMPTY.
    - push && pop → stay ONE; the head loads i_result.
    - neither → hold.
  - FULL: o_valid=1, o_ready=0.
    - pop → ONE; the skid moves into the head.
    - No push is possible in this state.
- Latency: a result pushed in cycle N is visible on o_valid/o_sum in cycle N+1 if the buffer was EMPTY.
- Ordering: strict FIFO order.
- Output stability: while o_valid=1 && i_ready=0, o_sum and o_carry hold steady.
- Statistics:
  - On each push, o_xfer_count increments by 1.
  - On each push with i_result[WIDTH]=1, o_carry_count increments by 1.
  - Both counters are registered and saturate at 2^CNT_WIDTH-1 (no wrap).
- Width rule: o_sum = i_result[WIDTH-1:0]; o_carry = i_result[WIDTH]; no arithmetic on the data.
- Head/skid registers keep their last content when not loaded. Their value is don't-care while o_valid=0, except after reset, when they are 0.

Decomposition:
- Shared package rca_pkg:
  - constant RCA_WIDTH=50
  - typedef rca_result_t (RCA_WIDTH+1 bits)
  - enum collector_state_t {EMPTY, ONE, FULL}
- One natural sub-module: sat_counter (parameter CNT_WIDTH, inputs i_clk/i_rst/i_inc, output count). It is instantiated twice, once per statistic.

Test Plan:
- Reset sequence: assert i_rst asynchronously mid-cycle with the buffer FULL → o_valid=0, o_ready=1, both counts=0 immediately, before the next edge.
- Single push with i_ready=1: push 0x0_0000_0000_0005 with carry=1 → next cycle o_valid=1, o_sum=5, o_carry=1; o_carry_count=1 and o_xfer_count=1.
- Backpressure: i_ready=0, push A=1 then B=2 → o_ready=0 after B; a third i_valid is ignored. Raise i_ready → outputs A then B on consecutive cycles, then o_valid=0.
- Simultaneous push/pop in ONE: stream 100 results with i_valid=i_ready=1 every cycle → one result per cycle, in order, o_ready stays 1, o_xfer_count=100.
- Saturation with CNT_WIDTH=4: push 20 results, all with carry=1 → both counts stop at 15.
- Carry boundary: push all-ones sum (2^50-1) with carry=0, then 0 with carry=1 → o_carry_count increments only on the second; o_sum matches bit-exactly.
